// File: rtl/uart_frame_sequencer_if.sv
// ----------------------------------------------------------------------------
// uart_frame_sequencer_if
//
// Bundles the control and status signals of uart_frame_sequencer.
//
// Handshake semantics: there is no valid/ready pair. start, bit_tick and
// abort are single-cycle strobes sampled on the rising clock edge. The
// configuration inputs are sampled only on the edge that accepts a start.
// All status outputs are registered.
//
// Signals (master = frame requester, slave = sequencer):
//   start          m->s  request a new frame
//   bit_tick       m->s  one-cycle strobe per UART bit period
//   abort          m->s  synchronous frame cancel
//   data_bits_cfg  m->s  requested data-field length [4:0]
//   two_stop       m->s  1 = two stop bits
//   parity_on      m->s  parity enable (only with UART_PARITY_EN defined)
//   phase          s->m  0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP
//   bit_index      s->m  data bit in progress, LSB first
//   busy           s->m  phase != IDLE
//   frame_done     s->m  one-cycle pulse at normal frame completion
//   start_err      s->m  one-cycle pulse when start arrives while busy
//
// Optional feature macro: UART_PARITY_EN (adds parity_on).
// ----------------------------------------------------------------------------
interface uart_frame_sequencer_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic             bit_tick;
    logic             abort;
    logic [4:0]       data_bits_cfg;
    logic             two_stop;
`ifdef UART_PARITY_EN
    logic             parity_on;
`endif
    logic [2:0]       phase;
    logic [IDX_W-1:0] bit_index;
    logic             busy;
    logic             frame_done;
    logic             start_err;

    modport master (
`ifdef UART_PARITY_EN
        output parity_on,
`endif
        output start,
        output bit_tick,
        output abort,
        output data_bits_cfg,
        output two_stop,
        input  phase,
        input  bit_index,
        input  busy,
        input  frame_done,
        input  start_err
    );

    modport slave (
`ifdef UART_PARITY_EN
        input  parity_on,
`endif
        input  start,
        input  bit_tick,
        input  abort,
        input  data_bits_cfg,
        input  two_stop,
        output phase,
        output bit_index,
        output busy,
        output frame_done,
        output start_err
    );
endinterface

// File: rtl/uart_frame_sequencer.sv
// ----------------------------------------------------------------------------
// uart_frame_sequencer
//
// Sequences the phases of one UART frame (START, DATA, optional PARITY,
// STOP) driven by a per-bit strobe. Frame configuration is captured when
// the frame is accepted, so the requester may change it freely mid-frame.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    uart_frame_sequencer_if.slave (see interface header)
//
// Parameters:
//   DATA_BITS_MAX  largest data-field length (5..16)
//   IDX_W          width of bit_index, must hold DATA_BITS_MAX-1
//
// Optional feature macro: UART_PARITY_EN -- adds the parity_on input and
// the PARITY phase. Without it DATA always proceeds straight to STOP.
//
// The phase output is the FSM state register itself and serves as the
// debug view of the state machine.
// ----------------------------------------------------------------------------
module uart_frame_sequencer #(
    parameter int DATA_BITS_MAX = 9,
    parameter int IDX_W         = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_frame_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_START  = 3'd1,
        PH_DATA   = 3'd2,
        PH_PARITY = 3'd3,
        PH_STOP   = 3'd4
    } phase_e;

    localparam logic [4:0] LEN_MIN = 5'd5;
    localparam logic [4:0] LEN_MAX = 5'(DATA_BITS_MAX);

    phase_e           phase_q,      phase_d;
    logic [IDX_W-1:0] bit_index_q,  bit_index_d;
    logic [4:0]       len_q,        len_d;
    logic             two_stop_q,   two_stop_d;
`ifdef UART_PARITY_EN
    logic             parity_q,     parity_d;
`endif
    // Set after the first of two stop ticks has been seen.
    logic             stop_cnt_q,   stop_cnt_d;
    logic             busy_q,       busy_d;
    logic             frame_done_q, frame_done_d;
    logic             start_err_q,  start_err_d;

    logic [4:0]       cfg_len;
    logic             last_data;

    // Clamp the requested length into the supported range.
    always_comb begin
        cfg_len = bus.data_bits_cfg;
        if (bus.data_bits_cfg < LEN_MIN) begin
            cfg_len = LEN_MIN;
        end else if (bus.data_bits_cfg > LEN_MAX) begin
            cfg_len = LEN_MAX;
        end
    end

    assign last_data = (32'(bit_index_q) == (32'(len_q) - 32'd1));

    always_comb begin
        phase_d      = phase_q;
        bit_index_d  = bit_index_q;
        len_d        = len_q;
        two_stop_d   = two_stop_q;
`ifdef UART_PARITY_EN
        parity_d     = parity_q;
`endif
        stop_cnt_d   = stop_cnt_q;
        frame_done_d = 1'b0;
        start_err_d  = 1'b0;

        if (bus.abort) begin
            // Cancel wins over everything, including a start in IDLE and
            // a final stop tick arriving in the same cycle.
            phase_d     = PH_IDLE;
            bit_index_d = '0;
        end else begin
            if ((phase_q != PH_IDLE) && bus.start) begin
                start_err_d = 1'b1;
            end

            case (phase_q)
                PH_IDLE: begin
                    // A tick arriving with start is deliberately ignored.
                    if (bus.start) begin
                        phase_d     = PH_START;
                        bit_index_d = '0;
                        len_d       = cfg_len;
                        two_stop_d  = bus.two_stop;
`ifdef UART_PARITY_EN
                        parity_d    = bus.parity_on;
`endif
                        stop_cnt_d  = 1'b0;
                    end
                end
                PH_START: begin
                    if (bus.bit_tick) begin
                        phase_d     = PH_DATA;
                        bit_index_d = '0;
                    end
                end
                PH_DATA: begin
                    if (bus.bit_tick) begin
                        if (last_data) begin
                            // bit_index holds the last data index from here on.
`ifdef UART_PARITY_EN
                            phase_d = parity_q ? PH_PARITY : PH_STOP;
`else
                            phase_d = PH_STOP;
`endif
                        end else begin
                            bit_index_d = bit_index_q + IDX_W'(1);
                        end
                    end
                end
                PH_PARITY: begin
                    if (bus.bit_tick) begin
                        phase_d = PH_STOP;
                    end
                end
                PH_STOP: begin
                    if (bus.bit_tick) begin
                        if (two_stop_q && !stop_cnt_q) begin
                            stop_cnt_d = 1'b1;
                        end else begin
                            phase_d      = PH_IDLE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                end
            endcase
        end

        busy_d = (phase_d != PH_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q      <= PH_IDLE;
            bit_index_q  <= '0;
            len_q        <= '0;
            two_stop_q   <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q     <= 1'b0;
`endif
            stop_cnt_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            bit_index_q  <= bit_index_d;
            len_q        <= len_d;
            two_stop_q   <= two_stop_d;
`ifdef UART_PARITY_EN
            parity_q     <= parity_d;
`endif
            stop_cnt_q   <= stop_cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            start_err_q  <= start_err_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.bit_index  = bit_index_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.start_err  = start_err_q;

endmodule

// File: doc/uart_frame_sequencer.md
UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

Interface
REQ-001 Parameter DATA_BITS_MAX, default 9, SHALL be the largest data-field length supported (legal range 5..16).
REQ-002 Parameter IDX_W, default 4, SHALL be the width of bit_index (must hold DATA_BITS_MAX-1).
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new frame.
REQ-006 bit_tick  input  1  one-cycle strobe, one per UART bit period.
REQ-007 abort  input  1  synchronous frame cancel.
REQ-008 data_bits_cfg  input  5  requested data-field length.
REQ-009 two_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 parity_on  input  1  enables parity bit (present only under UART_PARITY_EN).
REQ-011 phase  output  3  0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
REQ-012 bit_index  output  IDX_W  data bit in progress (LSB-first index).
REQ-013 busy  output  1  high whenever phase != IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at normal frame completion.
REQ-015 start_err  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-016 In IDLE, start=1 SHALL move to START on the next edge; data_bits_cfg, two_stop and parity_on SHALL be latched on that edge.
REQ-017 Latched length SHALL clamp: values <5 become 5; values >DATA_BITS_MAX become DATA_BITS_MAX.
REQ-018 START SHALL move to DATA with bit_index=0 on the first bit_tick.
REQ-019 In DATA, each bit_tick SHALL increment bit_index; a tick with bit_index = length-1 SHALL move to PARITY (if latched parity_on) else STOP.
REQ-020 PARITY SHALL move to STOP on one bit_tick.
REQ-021 STOP SHALL last 1 or 2 bit_ticks per latched two_stop; on the final tick it SHALL move to IDLE and assert frame_done for exactly that one cycle (registered, visible the cycle phase reads IDLE).
REQ-022 bit_index SHALL hold its value outside DATA except being cleared to 0 on entry to START.
REQ-023 bit_tick in IDLE SHALL have no effect; bit_tick together with start in IDLE SHALL accept start and ignore the tick.
REQ-024 start while busy SHALL be ignored and pulse start_err for one cycle; the frame SHALL continue unchanged.
REQ-025 abort SHALL have highest priority: next edge phase=IDLE, bit_index=0, no frame_done; abort with start in IDLE SHALL leave the block IDLE.
REQ-026 Changes to data_bits_cfg, two_stop or parity_on during a frame SHALL not affect that frame.
REQ-027 Latency start to phase=START SHALL be one clock; no state other than IDLE SHALL advance without bit_tick.

Reset
REQ-028 reset=0 SHALL immediately force phase=IDLE, bit_index=0, busy=0, frame_done=0, start_err=0, all latched configuration to 0, regardless of clk.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse; after release the block SHALL wait in IDLE for start.

Configuration
REQ-030 Macro UART_PARITY_EN defined: parity_on port and PARITY state SHALL exist per REQ-019/020.
REQ-031 Macro UART_PARITY_EN undefined: parity_on port SHALL be absent, PARITY SHALL be unreachable, DATA SHALL always proceed to STOP.

Verification
REQ-032 cfg=8, two_stop=0, parity off, start then 10 ticks -> phases START,DATA(idx 0..7),STOP; frame_done on tick 10 only.
REQ-033 UART_PARITY_EN, cfg=7, parity_on=1, two_stop=1, 11 ticks -> PARITY after idx 6, two STOP ticks, frame_done after tick 11.
REQ-034 cfg=3 then cfg=20 (DATA_BITS_MAX=9) -> frame uses 5 then 9 data bits.
REQ-035 start during DATA idx 4 -> start_err one cycle, frame completes normally; abort at idx 2 -> IDLE next edge, no frame_done.
REQ-036 reset low asynchronously mid-STOP -> outputs zero before next clk edge; after release, start with tick same cycle -> START, tick ignored.
